// File: rtl/fetch_mem_sequencer.sv
// Multi-cycle sequencer that shares one memory port between instruction fetch
// and load/store data accesses, and gates the datapath one step per instruction.
module fetch_mem_sequencer #(
  parameter int Dbits = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [Dbits-1:0] pc,
  input  logic [Dbits-1:0] mem_addr,
  input  logic [Dbits-1:0] mem_writedata,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             werf_in,
  output logic [31:0]      instr,
  output logic [Dbits-1:0] mem_readdata,
  output logic             dp_enable,
  output logic             werf_out,
  output logic             bus_req,
  output logic             bus_we,
  output logic [Dbits-1:0] bus_addr,
  output logic [Dbits-1:0] bus_wdata,
  input  logic [Dbits-1:0] bus_rdata,
  input  logic             bus_ready,
  output logic [31:0]      instret
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, COMMIT} state_t;

  state_t state, next_state;
  logic   fetch_done;
  logic   load_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A simultaneous rd+wr decode is serviced as a store, so bus_we follows mem_wr alone.
  always_comb begin
    next_state = state;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    dp_enable  = 1'b0;
    fetch_done = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end
      FETCH: begin
        bus_req  = 1'b1;
        bus_addr = pc;
        if (bus_ready) begin
          fetch_done = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (mem_rd || mem_wr) begin
          next_state = MEM;
        end else begin
          dp_enable  = 1'b1;
          next_state = run ? FETCH : IDLE;
        end
      end
      MEM: begin
        bus_req   = 1'b1;
        bus_we    = mem_wr;
        bus_addr  = mem_addr;
        bus_wdata = mem_writedata;
        if (bus_ready) begin
          load_done  = mem_rd && !mem_wr;
          next_state = COMMIT;
        end
      end
      COMMIT: begin
        dp_enable  = 1'b1;
        next_state = run ? FETCH : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign werf_out = werf_in & dp_enable;

  // dp_enable is asserted exactly on retire cycles, so it doubles as the retire strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr        <= '0;
      mem_readdata <= '0;
      instret      <= '0;
    end else begin
      if (fetch_done) instr <= 32'(bus_rdata);
      if (load_done)  mem_readdata <= bus_rdata;
      if (dp_enable)  instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Self-checking bench for fetch_mem_sequencer: directed vector table, corner-case
// sequences, and randomized instruction streams checked against a latency model.
module tb_fetch_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] pc = '0, mem_addr = '0, mem_writedata = '0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0, werf_in = 1'b0;
  logic [31:0] instr, mem_readdata, bus_addr, bus_wdata, instret;
  logic        dp_enable, werf_out, bus_req, bus_we;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  fetch_mem_sequencer #(.Dbits(32)) dut (
    .clock(clock), .reset(reset), .run(run), .pc(pc),
    .mem_addr(mem_addr), .mem_writedata(mem_writedata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .werf_in(werf_in),
    .instr(instr), .mem_readdata(mem_readdata),
    .dp_enable(dp_enable), .werf_out(werf_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .instret(instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        run, rdy, rd, wr, werf;
    logic [31:0] rdata;
    logic        e_req, e_we, e_dp, e_werf;
    logic [31:0] e_addr;
    logic [31:0] e_instret;
  } vec_t;

  vec_t tbl[16];

  task automatic applyStimulus(input logic r, input logic rdy, input logic rd,
                               input logic wr, input logic werf, input logic [31:0] rdat);
    run = r; bus_ready = rdy; mem_rd = rd; mem_wr = wr; werf_in = werf; bus_rdata = rdat;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".bus_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, ".dp_enable"}, 32'(dp_enable), 32'd0);
  endtask

  // Randomized-stream state
  int unsigned fw, mw, kind, total;
  logic        r_rd, r_wr, is_mem, is_load, e_req, e_we, e_dp, rdy, werf;
  logic [31:0] ipc, maddr, wd, word, ld, rdat, e_addr;
  logic [31:0] exp_instr, exp_mrd, exp_instret;

  initial begin
    tbl[0]  = '{1,1,0,0,1, 32'h0,        0,0,0,0, 32'h0,        0};
    tbl[1]  = '{1,1,0,0,1, 32'h00B50533, 1,0,0,0, 32'h00400000, 0};
    tbl[2]  = '{1,1,0,0,1, 32'h0,        0,0,1,1, 32'h0,        0};
    tbl[3]  = '{1,0,1,0,1, 32'h11111111, 1,0,0,0, 32'h00400000, 1};
    tbl[4]  = '{1,1,1,0,1, 32'h0000A283, 1,0,0,0, 32'h00400000, 1};
    tbl[5]  = '{1,0,1,0,1, 32'h0,        0,0,0,0, 32'h0,        1};
    tbl[6]  = '{1,1,1,0,1, 32'hDEADBEEF, 1,0,0,0, 32'h00001000, 1};
    tbl[7]  = '{1,1,1,0,1, 32'h0,        0,0,1,1, 32'h0,        1};
    tbl[8]  = '{1,1,0,1,0, 32'h00A02023, 1,0,0,0, 32'h00400000, 2};
    tbl[9]  = '{1,1,0,1,0, 32'h0,        0,0,0,0, 32'h0,        2};
    tbl[10] = '{1,1,0,1,0, 32'h12345678, 1,1,0,0, 32'h00001000, 2};
    tbl[11] = '{0,1,0,1,0, 32'h0,        0,0,1,0, 32'h0,        2};
    tbl[12] = '{0,1,0,0,0, 32'h0,        0,0,0,0, 32'h0,        3};
    tbl[13] = '{0,1,0,0,1, 32'h0,        0,0,0,0, 32'h0,        3};
    tbl[14] = '{1,0,0,0,1, 32'h0,        0,0,0,0, 32'h0,        3};
    tbl[15] = '{1,0,0,0,1, 32'h0,        1,0,0,0, 32'h00400000, 3};

    // Reset values
    #1;
    checkOutput("rst.bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst.bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst.dp_enable", 32'(dp_enable), 32'd0);
    checkOutput("rst.werf_out", 32'(werf_out), 32'd0);
    checkOutput("rst.instr", instr, 32'd0);
    checkOutput("rst.mem_readdata", mem_readdata, 32'd0);
    checkOutput("rst.instret", instret, 32'd0);

    // Directed vector table: add, load, store, then run dropped
    pc = 32'h00400000; mem_addr = 32'h00001000; mem_writedata = 32'hCAFEF00D;
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].run, tbl[i].rdy, tbl[i].rd, tbl[i].wr, tbl[i].werf, tbl[i].rdata);
      #1;
      checkOutput($sformatf("tbl%0d.bus_req", i), 32'(bus_req), 32'(tbl[i].e_req));
      checkOutput($sformatf("tbl%0d.bus_we", i), 32'(bus_we), 32'(tbl[i].e_we));
      checkOutput($sformatf("tbl%0d.dp_enable", i), 32'(dp_enable), 32'(tbl[i].e_dp));
      checkOutput($sformatf("tbl%0d.werf_out", i), 32'(werf_out), 32'(tbl[i].e_werf));
      checkOutput($sformatf("tbl%0d.instret", i), instret, tbl[i].e_instret);
      if (tbl[i].e_req) checkOutput($sformatf("tbl%0d.bus_addr", i), bus_addr, tbl[i].e_addr);
      if (tbl[i].e_we) checkOutput($sformatf("tbl%0d.bus_wdata", i), bus_wdata, 32'hCAFEF00D);
      @(negedge clock);
    end
    checkOutput("tbl.instr", instr, 32'h00A02023);
    checkOutput("tbl.mem_readdata", mem_readdata, 32'hDEADBEEF);

    // Store held in MEM by three wait cycles
    mem_addr = 32'h00002000; mem_writedata = 32'hA5A50F0F;
    doReset();
    applyStimulus(1, 1, 0, 1, 1, 32'h0); #1; checkQuiet("st.idle");
    @(negedge clock);
    applyStimulus(1, 1, 0, 1, 1, 32'h00A02023); #1;
    checkOutput("st.fetch.bus_req", 32'(bus_req), 32'd1);
    @(negedge clock);
    applyStimulus(1, 1, 0, 1, 1, 32'h0); #1; checkQuiet("st.exec");
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      applyStimulus(1, logic'(j == 3), 0, 1, 1, 32'h77777777); #1;
      checkOutput($sformatf("st.mem%0d.bus_req", j), 32'(bus_req), 32'd1);
      checkOutput($sformatf("st.mem%0d.bus_we", j), 32'(bus_we), 32'd1);
      checkOutput($sformatf("st.mem%0d.bus_addr", j), bus_addr, 32'h00002000);
      checkOutput($sformatf("st.mem%0d.bus_wdata", j), bus_wdata, 32'hA5A50F0F);
      checkOutput($sformatf("st.mem%0d.dp_enable", j), 32'(dp_enable), 32'd0);
      checkOutput($sformatf("st.mem%0d.instret", j), instret, 32'd0);
    end
    @(negedge clock);
    applyStimulus(0, 1, 0, 1, 1, 32'h0); #1;
    checkOutput("st.commit.dp_enable", 32'(dp_enable), 32'd1);
    checkOutput("st.commit.werf_out", 32'(werf_out), 32'd1);
    for (int j = 0; j < 2; j++) begin
      @(negedge clock); #1;
      checkQuiet($sformatf("st.after%0d", j));
      checkOutput($sformatf("st.after%0d.instret", j), instret, 32'd1);
      checkOutput($sformatf("st.after%0d.mem_readdata", j), mem_readdata, 32'd0);
    end

    // Run dropped during EXEC
    doReset();
    applyStimulus(1, 1, 0, 0, 1, 32'h0); #1; checkQuiet("rd.idle");
    @(negedge clock);
    applyStimulus(1, 1, 0, 0, 1, 32'h00000013); #1;
    checkOutput("rd.fetch.bus_req", 32'(bus_req), 32'd1);
    @(negedge clock);
    applyStimulus(0, 1, 0, 0, 1, 32'h0); #1;
    checkOutput("rd.exec.dp_enable", 32'(dp_enable), 32'd1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock); #1;
      checkQuiet($sformatf("rd.idle%0d", j));
      checkOutput($sformatf("rd.idle%0d.instret", j), instret, 32'd1);
    end
    @(negedge clock);
    applyStimulus(1, 1, 0, 0, 1, 32'h0); #1; checkQuiet("rd.resample");
    @(negedge clock); #1;
    checkOutput("rd.refetch.bus_req", 32'(bus_req), 32'd1);

    // Reset during a FETCH wait
    doReset();
    applyStimulus(1, 1, 0, 0, 1, 32'h0);
    @(negedge clock);
    applyStimulus(1, 1, 0, 0, 1, 32'h00000033);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(1, 0, 0, 0, 1, 32'h0); #1;
    checkOutput("rf.wait.bus_req", 32'(bus_req), 32'd1);
    checkOutput("rf.wait.instret", instret, 32'd1);
    @(negedge clock);
    reset = 1'b1; #1;
    checkQuiet("rf.rst");
    checkOutput("rf.rst.instret", instret, 32'd0);
    checkOutput("rf.rst.instr", instr, 32'd0);
    @(negedge clock);
    applyStimulus(1, 1, 0, 0, 1, 32'h0); #1; checkQuiet("rf.held");
    @(negedge clock);
    reset = 1'b0; #1; checkQuiet("rf.release");
    @(negedge clock); #1;
    checkOutput("rf.first_req", 32'(bus_req), 32'd1);
    checkOutput("rf.first_req.instret", instret, 32'd0);

    // instret wrap
    doReset();
    force dut.instret = 32'hFFFFFFFF;
    #1;
    release dut.instret;
    applyStimulus(1, 1, 0, 0, 1, 32'h0);
    @(negedge clock);
    @(negedge clock);
    applyStimulus(0, 1, 0, 0, 1, 32'h0); #1;
    checkOutput("wrap.dp_enable", 32'(dp_enable), 32'd1);
    @(negedge clock); #1;
    checkOutput("wrap.instret", instret, 32'd0);

    // Randomized instruction stream against a latency model
    doReset();
    exp_instr = '0; exp_mrd = '0; exp_instret = '0;
    applyStimulus(1, 1, 0, 0, 0, 32'h0); #1; checkQuiet("rnd.idle");
    @(negedge clock);
    for (int n = 0; n < 60; n++) begin
      fw = $urandom_range(0, 2); mw = $urandom_range(0, 2); kind = $urandom_range(0, 3);
      r_rd = (kind == 1) || (kind == 3);
      r_wr = (kind == 2) || (kind == 3);
      is_mem = r_rd | r_wr;
      is_load = r_rd & ~r_wr;
      ipc = $urandom; maddr = $urandom; wd = $urandom; word = $urandom; ld = $urandom;
      total = is_mem ? fw + mw + 4 : fw + 2;
      pc = ipc; mem_addr = maddr; mem_writedata = wd;
      for (int unsigned k = 0; k < total; k++) begin
        e_req = 0; e_we = 0; e_dp = 0; e_addr = '0;
        rdy = 1'($urandom_range(0, 1)); rdat = $urandom;
        if (k <= fw) begin
          e_req = 1; e_addr = ipc; rdy = (k == fw);
          if (rdy) rdat = word;
        end else if (k == fw + 1) begin
          e_dp = ~is_mem;
        end else if (k <= fw + 2 + mw) begin
          e_req = 1; e_we = r_wr; e_addr = maddr; rdy = (k == fw + 2 + mw);
          if (rdy) rdat = ld;
        end else begin
          e_dp = 1;
        end
        werf = 1'($urandom_range(0, 1));
        applyStimulus(1, rdy, r_rd, r_wr, werf, rdat);
        #1;
        checkOutput("rnd.bus_req", 32'(bus_req), 32'(e_req));
        checkOutput("rnd.bus_we", 32'(bus_we), 32'(e_we));
        checkOutput("rnd.dp_enable", 32'(dp_enable), 32'(e_dp));
        checkOutput("rnd.werf_out", 32'(werf_out), 32'(werf & e_dp));
        checkOutput("rnd.instret", instret, exp_instret);
        checkOutput("rnd.instr", instr, exp_instr);
        checkOutput("rnd.mem_readdata", mem_readdata, exp_mrd);
        if (e_req) checkOutput("rnd.bus_addr", bus_addr, e_addr);
        if (e_we) checkOutput("rnd.bus_wdata", bus_wdata, wd);
        @(posedge clock);
        if (k == fw) exp_instr = word;
        if (is_load && k == fw + 2 + mw) exp_mrd = ld;
        if (e_dp) exp_instret = exp_instret + 32'd1;
        @(negedge clock);
      end
    end
    #1;
    checkOutput("rnd.final.instret", instret, exp_instret);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
